// File: rtl/ram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ram_arbiter : round-robin arbiter sharing one read-latency-1 RAM among ports.
// Optional macro RAM_ARBITER_FIXED_PRIO_EN: fixed priority, port 0 highest.
// Revision: 1.0
// -----------------------------------------------------------------------------
module ram_arbiter #(
  parameter  int WORD_SIZE = -1,
  parameter  int RAM_SIZE  = -1,
  parameter  int NUM_PORTS = 2,
  localparam int WS        = (WORD_SIZE > 0) ? WORD_SIZE : 1,
  localparam int DEPTH     = (RAM_SIZE > 1) ? RAM_SIZE : 2,
  localparam int ADDR_BITW = $clog2(DEPTH),
  localparam int PORT_BITW = $clog2(NUM_PORTS)
) (
  input  logic                           clock,
  input  logic                           n_rst,
  input  logic [NUM_PORTS-1:0]           req,
  input  logic [NUM_PORTS-1:0]           we,
  input  logic [NUM_PORTS*ADDR_BITW-1:0] addr,
  input  logic [NUM_PORTS*WS-1:0]        wdata,
  output logic [NUM_PORTS-1:0]           gnt,
  output logic [NUM_PORTS-1:0]           rvalid,
  output logic [WS-1:0]                  rdata
);

  logic [WS-1:0]        mem [DEPTH];
  logic [WS-1:0]        rd_word_q;
  logic                 rd_pend_q;
  logic [PORT_BITW-1:0] rd_port_q;

  logic                 sel_vld;
  logic [PORT_BITW-1:0] sel_idx;
  logic [PORT_BITW-1:0] cand;
  logic                 sel_we;
  logic [ADDR_BITW-1:0] sel_addr;
  logic [WS-1:0]        sel_wdata;
  logic                 grant;

`ifndef RAM_ARBITER_FIXED_PRIO_EN
  logic [PORT_BITW-1:0] last_q;
  logic [PORT_BITW:0]   sum;
`endif

  // Scan ports in priority order; the first requester wins and its fields are muxed out.
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    cand      = '0;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
    sum       = '0;
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
`ifdef RAM_ARBITER_FIXED_PRIO_EN
      cand = PORT_BITW'(i);
`else
      sum = {1'b0, last_q} + (PORT_BITW+1)'(i + 1);
      if (sum >= (PORT_BITW+1)'(NUM_PORTS)) begin
        sum = sum - (PORT_BITW+1)'(NUM_PORTS);
      end
      cand = sum[PORT_BITW-1:0];
`endif
      if (!sel_vld && req[cand]) begin
        sel_vld   = 1'b1;
        sel_idx   = cand;
        sel_we    = we[cand];
        sel_addr  = addr[cand*ADDR_BITW +: ADDR_BITW];
        sel_wdata = wdata[cand*WS +: WS];
      end
    end
  end

  assign grant = sel_vld & n_rst;

  always_comb begin
    gnt = '0;
    if (grant) begin
      gnt[sel_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      rd_pend_q <= 1'b0;
      rd_port_q <= '0;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
      last_q    <= PORT_BITW'(NUM_PORTS - 1);
`endif
    end else begin
      rd_pend_q <= grant & ~sel_we;
      if (grant) begin
        rd_port_q <= sel_idx;
`ifndef RAM_ARBITER_FIXED_PRIO_EN
        last_q    <= sel_idx;
`endif
      end
    end
  end

  // Storage is deliberately left unreset; the read register is masked by rd_pend_q.
  always_ff @(posedge clock) begin
    if (grant) begin
      if (sel_we) begin
        mem[sel_addr] <= sel_wdata;
      end else begin
        rd_word_q <= mem[sel_addr];
      end
    end
  end

  assign rvalid = rd_pend_q ? (NUM_PORTS'(1) << rd_port_q) : '0;
  assign rdata  = rd_pend_q ? rd_word_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter : directed plus random stimulus checked against a behavioural
// model (array memory, rotating-priority search, one-deep read return).
module tb_ram_arbiter;
  localparam int N     = 3;
  localparam int AB    = 4;
  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic             clock = 1'b0;
  logic             n_rst = 1'b0;
  logic [N-1:0]     req   = '0;
  logic [N-1:0]     we    = '0;
  logic [N*AB-1:0]  addr  = '0;
  logic [N*W-1:0]   wdata = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rvalid;
  logic [W-1:0]     rdata;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_mem [DEPTH];
  int           m_last = N - 1;
  bit           m_pend = 1'b0;
  int           m_pport = 0;
  logic [W-1:0] m_pdata = '0;
  int           last_w = -1;
  int           g1cnt = 0;

  ram_arbiter #(.WORD_SIZE(W), .RAM_SIZE(DEPTH), .NUM_PORTS(N)) dut (
    .clock  (clock),
    .n_rst  (n_rst),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata)
  );

  always #5 clock = ~clock;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setp(int p, bit r, bit w, int a, int d);
    req[p]            = r;
    we[p]             = w;
    addr[p*AB +: AB]  = AB'(a);
    wdata[p*W +: W]   = W'(d);
  endtask

  // Winner = first requester when walking the ports after the last one served.
  function automatic int winner();
    for (int k = 1; k <= N; k++) begin
      int p;
`ifdef RAM_ARBITER_FIXED_PRIO_EN
      p = k - 1;
`else
      p = (m_last + k) % N;
`endif
      if (req[p]) return p;
    end
    return -1;
  endfunction

  task automatic tick(string tag);
    int           w;
    int           a;
    logic [N-1:0] eg;
    logic [N-1:0] erv;
    @(negedge clock);
    w  = winner();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    erv = m_pend ? (N'(1) << m_pport) : '0;
    chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ":rvalid"}, 32'(rvalid), 32'(erv));
    chk({tag, ":rdata"}, 32'(rdata), m_pend ? 32'(m_pdata) : 32'd0);
    if (gnt[1] === 1'b1) g1cnt++;
    @(posedge clock);
    m_pend = 1'b0;
    if (w >= 0) begin
      m_last = w;
      a = int'(addr[w*AB +: AB]);
      if (we[w]) begin
        m_mem[a] = wdata[w*W +: W];
      end else begin
        m_pend  = 1'b1;
        m_pport = w;
        m_pdata = m_mem[a];
      end
    end
    last_w = w;
    #1;
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) setp(p, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with requests pending: nothing may be granted or returned.
    req = '1;
    repeat (2) begin
      @(negedge clock);
      chk("rst:gnt", 32'(gnt), 32'd0);
      chk("rst:rvalid", 32'(rvalid), 32'd0);
      chk("rst:rdata", 32'(rdata), 32'd0);
    end
    @(posedge clock);
    #1;
    n_rst = 1'b1;
    clear_all();

    // Port 2 alone fills the memory with back-to-back writes.
    for (int a = 0; a < DEPTH; a++) begin
      setp(2, 1, 1, a, int'($urandom));
      tick("fill");
    end
    clear_all();

    // Write 0x5A at addr 3 from port 0, read it back from port 1 next cycle.
    setp(0, 1, 1, 3, 8'h5A);
    tick("rw_w");
    setp(0, 0, 0, 0, 0);
    setp(1, 1, 0, 3, 0);
    tick("rw_r");
    setp(1, 0, 0, 0, 0);
    tick("rw_ret");
    chk("rw_data", 32'(m_pdata), 32'h5A);

    // All ports hold reads to 0/1/2: grants rotate.
    for (int p = 0; p < N; p++) setp(p, 1, 0, p, 0);
    repeat (6) tick("rr3");
    clear_all();
    tick("rr3_drain");

    // Port 1 alone streams reads to 4,5,6.
    for (int a = 4; a <= 6; a++) begin
      setp(1, 1, 0, a, 0);
      tick("b2b");
    end
    clear_all();
    tick("b2b_drain");

    // Reset pulse while a read is in flight drops it.
    setp(0, 1, 0, 7, 0);
    tick("inflight");
    setp(0, 0, 0, 0, 0);
    setp(1, 1, 0, 1, 0);
    n_rst = 1'b0;
    @(negedge clock);
    chk("rstfl:gnt", 32'(gnt), 32'd0);
    chk("rstfl:rvalid", 32'(rvalid), 32'd0);
    chk("rstfl:rdata", 32'(rdata), 32'd0);
    @(posedge clock);
    #1;
    n_rst  = 1'b1;
    m_last = N - 1;
    m_pend = 1'b0;
    last_w = -1;
    for (int p = 0; p < N; p++) setp(p, 1, 0, p + 8, 0);
    tick("post_rst");
    clear_all();
    tick("post_rst_drain");

    // Ports 0 and 1 contend for ten cycles.
    setp(0, 1, 0, 9, 0);
    setp(1, 1, 0, 10, 0);
    g1cnt = 0;
    repeat (10) tick("cont");
`ifdef RAM_ARBITER_FIXED_PRIO_EN
    chk("cont:g1count", 32'(g1cnt), 32'd0);
`else
    chk("cont:g1count", 32'(g1cnt), 32'd5);
`endif
    clear_all();

    // Idle, then contention must resume from the preserved pointer.
    repeat (5) tick("idle");
    for (int p = 0; p < N; p++) setp(p, 1, p[0], p + 11, 8'hC0 + p);
    repeat (3) tick("after_idle");
    clear_all();
    last_w = -1;

    // Random traffic with the hold-until-granted handshake and occasional withdrawal.
    repeat (400) begin
      for (int p = 0; p < N; p++) begin
        if (last_w == p || !req[p]) begin
          if ($urandom_range(0, 2) != 0)
            setp(p, 1, bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), int'($urandom));
          else
            setp(p, 0, 0, 0, 0);
        end else if ($urandom_range(0, 9) == 0) begin
          setp(p, 0, 0, 0, 0);
        end
      end
      tick("rand");
    end
    clear_all();
    tick("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
